mul_norm_round: RTL and testbench

Two-stage pipelined normalize-and-round stage for the single-precision pipelined multiplier. It sits between the 24x24 significand multiplier and the final output/flag stage. It takes the raw 48-bit significand product and the biased exponent sum, then normalizes and rounds the result to nearest-even. It also handles the subnormal/underflow range and detects overflow. It emits a 24-bit significand (hidden bit included), an 8-bit exponent, the sign and the exception flags the output stage consumes.

---
 rtl/mul_norm_round.sv | 198 +++++++++++++++++++
 tb/tb_mul_norm_round.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_norm_round.sv
`default_nettype none
//==============================================================================
// mul_norm_round: 2-stage normalize + round-to-nearest-even for the binary32 multiplier.
// SUBNORMAL_EN selects gradual underflow (otherwise flush-to-zero). Rev 1.0
//==============================================================================
module mul_norm_round (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [47:0] prod_in,
    input  logic [9:0]  exp_sum_in,
    input  logic        sign_in,
    input  logic        zero_in,
    input  logic        invalid_in,
    output logic        out_valid,
    output logic [23:0] M_out,
    output logic [7:0]  E_out,
    output logic        Sz_out,
    output logic        overflow_flag,
    output logic        underflow_case,
    output logic        inexact_flag,
    output logic        initial_zero_flag,
    output logic        invalid_flag
);

    logic               s1_valid, s1_g, s1_s, s1_sign, s1_zero, s1_inv;
    logic [23:0]        s1_mant;
    logic signed [9:0]  s1_exp;

    logic [23:0]        n_mant;
    logic               n_g, n_s;
    logic signed [9:0]  n_exp;

    always_comb begin
        if (prod_in[47]) begin
            n_mant = prod_in[47:24];
            n_g    = prod_in[23];
            n_s    = |prod_in[22:0];
            n_exp  = $signed(exp_sum_in) + 10'sd1;
        end else begin
            n_mant = prod_in[46:23];
            n_g    = prod_in[22];
            n_s    = |prod_in[21:0];
            n_exp  = $signed(exp_sum_in);
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid <= 1'b0;
            s1_mant  <= '0;
            s1_g     <= 1'b0;
            s1_s     <= 1'b0;
            s1_exp   <= '0;
            s1_sign  <= 1'b0;
            s1_zero  <= 1'b0;
            s1_inv   <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_mant  <= n_mant;
                s1_g     <= n_g;
                s1_s     <= n_s;
                s1_exp   <= n_exp;
                s1_sign  <= sign_in;
                s1_zero  <= zero_in;
                s1_inv   <= invalid_in;
            end
        end
    end

    logic               tiny;
    logic [23:0]        dn_mant;
    logic               dn_g, dn_s;
    logic signed [10:0] dn_exp;

    assign tiny = (s1_exp <= 10'sd0);

`ifdef SUBNORMAL_EN
    logic [9:0]  sh_raw;
    logic [4:0]  sh;
    logic [49:0] shifted;

    // Shift amount saturates at 26: beyond that every mantissa bit lands in sticky.
    always_comb begin
        sh_raw  = 10'd1 - $unsigned(s1_exp);
        sh      = (sh_raw > 10'd26) ? 5'd26 : sh_raw[4:0];
        shifted = {s1_mant, 26'd0} >> sh;
        if (tiny) begin
            dn_mant = shifted[49:26];
            dn_g    = shifted[25];
            dn_s    = (|shifted[24:0]) | s1_g | s1_s;
            dn_exp  = 11'sd0;
        end else begin
            dn_mant = s1_mant;
            dn_g    = s1_g;
            dn_s    = s1_s;
            dn_exp  = {s1_exp[9], s1_exp};
        end
    end
`else
    logic nonzero;

    assign nonzero = (|s1_mant) | s1_g | s1_s;

    always_comb begin
        dn_mant = s1_mant;
        dn_g    = s1_g;
        dn_s    = s1_s;
        dn_exp  = {s1_exp[9], s1_exp};
    end
`endif

    logic               round_up, ovf, inexact;
    logic [24:0]        sum;
    logic [23:0]        rnd_mant;
    logic signed [10:0] rnd_exp;

    always_comb begin
        round_up = dn_g & (dn_s | dn_mant[0]);
        sum      = {1'b0, dn_mant} + {24'd0, round_up};
        if (sum[24]) begin
            rnd_mant = 24'h800000;
            rnd_exp  = dn_exp + 11'sd1;
        end else begin
            rnd_mant = sum[23:0];
            rnd_exp  = dn_exp;
        end
        // A subnormal that rounds into bit 23 becomes the smallest normal.
        if (rnd_exp == 11'sd0 && rnd_mant[23])
            rnd_exp = 11'sd1;
        ovf     = (rnd_exp >= 11'sd255);
        inexact = dn_g | dn_s | ovf;
    end

    logic [23:0] nx_m;
    logic [7:0]  nx_e;
    logic        nx_ov, nx_uf, nx_inx, nx_iz, nx_inv;

    always_comb begin
        nx_m   = '0;
        nx_e   = '0;
        nx_ov  = 1'b0;
        nx_uf  = 1'b0;
        nx_inx = 1'b0;
        nx_iz  = 1'b0;
        nx_inv = 1'b0;
        if (s1_inv) begin
            nx_m   = 24'hFFFFFF;
            nx_e   = 8'hFF;
            nx_inv = 1'b1;
        end else if (s1_zero) begin
            nx_iz  = 1'b1;
`ifndef SUBNORMAL_EN
        end else if (tiny) begin
            nx_uf  = nonzero;
            nx_inx = nonzero;
`endif
        end else if (ovf) begin
            nx_e   = 8'hFF;
            nx_ov  = 1'b1;
            nx_inx = 1'b1;
        end else begin
            nx_m   = rnd_mant;
            nx_e   = rnd_exp[7:0];
            nx_inx = inexact;
            nx_uf  = (rnd_exp[7:0] == 8'd0) & inexact;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid         <= 1'b0;
            M_out             <= '0;
            E_out             <= '0;
            Sz_out            <= 1'b0;
            overflow_flag     <= 1'b0;
            underflow_case    <= 1'b0;
            inexact_flag      <= 1'b0;
            initial_zero_flag <= 1'b0;
            invalid_flag      <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                M_out             <= nx_m;
                E_out             <= nx_e;
                Sz_out            <= s1_sign;
                overflow_flag     <= nx_ov;
                underflow_case    <= nx_uf;
                inexact_flag      <= nx_inx;
                initial_zero_flag <= nx_iz;
                invalid_flag      <= nx_inv;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_norm_round.sv
`default_nettype none
// Bench for mul_norm_round: directed and random operands against an arithmetic rounding model.
module tb_mul_norm_round;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        in_valid = 1'b0;
    logic [47:0] prod_in = '0;
    logic [9:0]  exp_sum_in = '0;
    logic        sign_in = 1'b0;
    logic        zero_in = 1'b0;
    logic        invalid_in = 1'b0;
    logic        out_valid;
    logic [23:0] M_out;
    logic [7:0]  E_out;
    logic        Sz_out, overflow_flag, underflow_case, inexact_flag;
    logic        initial_zero_flag, invalid_flag;

    mul_norm_round dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .prod_in(prod_in),
        .exp_sum_in(exp_sum_in), .sign_in(sign_in), .zero_in(zero_in),
        .invalid_in(invalid_in), .out_valid(out_valid), .M_out(M_out),
        .E_out(E_out), .Sz_out(Sz_out), .overflow_flag(overflow_flag),
        .underflow_case(underflow_case), .inexact_flag(inexact_flag),
        .initial_zero_flag(initial_zero_flag), .invalid_flag(invalid_flag)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [23:0] m;
        logic [7:0]  ex;
        logic        sz, ov, uf, inx, iz, inv;
    } res_t;

    res_t exp_q[$];
    int   due_q[$];
    res_t last = '0;
    int   cycle = 0;
    int   checks = 0;
    int   errors = 0;

    // Exact value scaled down by k, rounded to nearest-even with plain integer arithmetic.
    function automatic res_t model(input logic [47:0] p, input logic signed [9:0] es,
                                   input logic sg, input logic zr, input logic iv);
        res_t r;
        longint unsigned pv, q, rem, half;
        int e, k, base, sh;
        bit sub;
        r = '0;
        r.sz = sg;
        if (iv) begin
            r.inv = 1'b1; r.m = 24'hFFFFFF; r.ex = 8'hFF;
            return r;
        end
        if (zr) begin
            r.iz = 1'b1;
            return r;
        end
        pv = 64'(p);
        e = es;
        base = 23;
        if (pv >= (64'd1 << 47)) begin
            base = 24;
            e = e + 1;
        end
        sub = (e <= 0);
`ifndef SUBNORMAL_EN
        if (sub) begin
            if (pv != 0) begin r.uf = 1'b1; r.inx = 1'b1; end
            return r;
        end
`endif
        sh = sub ? (((1 - e) > 26) ? 26 : (1 - e)) : 0;
        k = base + sh;
        if (sub) e = 0;
        q = pv >> k;
        rem = pv - (q << k);
        half = 64'd1 << (k - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        r.inx = (rem != 0);
        if (q >= (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e = e + 1;
        end
        if (e == 0 && q >= (64'd1 << 23)) e = 1;
        if (e >= 255) begin
            r.ov = 1'b1; r.inx = 1'b1; r.ex = 8'hFF; r.m = '0;
        end else begin
            r.ex = e[7:0];
            r.m = q[23:0];
        end
        r.uf = (r.ex == 8'd0) && r.inx;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, expv, cycle);
        end
    endtask

    task automatic chk_res(input res_t r, input logic v);
        chk("out_valid", 32'(out_valid), 32'(v));
        chk("M_out", 32'(M_out), 32'(r.m));
        chk("E_out", 32'(E_out), 32'(r.ex));
        chk("Sz_out", 32'(Sz_out), 32'(r.sz));
        chk("overflow_flag", 32'(overflow_flag), 32'(r.ov));
        chk("underflow_case", 32'(underflow_case), 32'(r.uf));
        chk("inexact_flag", 32'(inexact_flag), 32'(r.inx));
        chk("initial_zero_flag", 32'(initial_zero_flag), 32'(r.iz));
        chk("invalid_flag", 32'(invalid_flag), 32'(r.inv));
    endtask

    // One clock: record the driven operand, advance, then compare (idle cycles must hold).
    task automatic step();
        res_t r;
        if (in_valid && RST) begin
            exp_q.push_back(model(prod_in, exp_sum_in, sign_in, zero_in, invalid_in));
            due_q.push_back(cycle + 2);
        end
        @(posedge CLK);
        cycle++;
        #1;
        in_valid = 1'b0;
        zero_in = 1'b0;
        invalid_in = 1'b0;
        if (due_q.size() > 0 && due_q[0] == cycle) begin
            r = exp_q.pop_front();
            void'(due_q.pop_front());
            last = r;
            chk_res(r, 1'b1);
        end else begin
            chk_res(last, 1'b0);
        end
    endtask

    task automatic send(input logic [47:0] p, input int es, input logic sg,
                        input logic zr, input logic iv);
        prod_in = p;
        exp_sum_in = 10'(es);
        sign_in = sg;
        zero_in = zr;
        invalid_in = iv;
        in_valid = 1'b1;
        step();
    endtask

    task automatic send_random();
        logic [23:0] a, b;
        logic [47:0] p;
        int es;
        a = {1'b1, 23'($urandom)};
        b = {1'b1, 23'($urandom)};
        p = ($urandom_range(0, 3) == 0) ? {16'($urandom), 32'($urandom)} : 48'(a) * 48'(b);
        es = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) - 125
                                         : int'($urandom_range(0, 506)) - 125;
        send(p, es, 1'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    endtask

    initial begin
        #1;
        chk_res('0, 1'b0);
        repeat (2) begin
            @(posedge CLK);
            cycle++;
        end
        #1;
        RST = 1'b1;
        chk_res('0, 1'b0);

        send(48'h900000000000, 127, 1'b0, 1'b0, 1'b0);
        step(); step();
        send({1'b0, 24'h800001, 1'b1, 22'd0}, 127, 1'b1, 1'b0, 1'b0);
        send({1'b0, 24'h800000, 1'b1, 22'd0}, 127, 1'b0, 1'b0, 1'b0);
        send({25'h1FFFFFF, 23'd0}, 100, 1'b0, 1'b0, 1'b0);
        send({1'b1, 47'd0}, 254, 1'b1, 1'b0, 1'b0);
        send({1'b0, 24'h800000, 23'd0}, -1, 1'b0, 1'b0, 1'b0);
        send({1'b0, 24'h8FFFFF, 23'd0}, -125, 1'b0, 1'b0, 1'b0);
        send({1'b0, 24'hFFFFFF, 23'h7FFFFF}, 0, 1'b0, 1'b0, 1'b0);
        send(48'h123456789ABC, 5, 1'b1, 1'b1, 1'b1);
        send(48'h123456789ABC, 5, 1'b1, 1'b1, 1'b0);
        send(48'd0, -30, 1'b0, 1'b0, 1'b0);
        step(); step(); step();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) step();
            else send_random();
        end
        step(); step(); step();

        repeat (4) send_random();
        step(); step(); step();

        send_random();
        send_random();
        RST = 1'b0;
        exp_q.delete();
        due_q.delete();
        last = '0;
        #1;
        chk_res('0, 1'b0);
        @(posedge CLK);
        cycle++;
        #1;
        RST = 1'b1;
        chk_res('0, 1'b0);
        step(); step();
        send_random();
        send_random();
        step(); step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
